// File: rtl/cmd_int.sv
// -----------------------------------------------------------------------------
// cmd_int -- byte-stream command interpreter between the UART and reg_top.
//
// This block decodes a command byte and acts on it:
//   bit7 = 1 : write. The command byte carries the address and the next byte
//              is the data. The write strobe goes to the register file.
//   bit7 = 0 : read. The command byte carries the address. The register byte
//              at that address is returned over a valid/ready handshake.
// A write command that receives no data byte within TIMEOUT_CYCLES cycles is
// abandoned and err_o pulses. A byte that arrives while the block is busy
// with a write strobe, a read or a transmit is dropped, and err_o pulses.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   rx_data_i, rx_valid_i  received byte and its one-cycle strobe
//   address_o              register address to reg_top
//   wr_o                   write command in progress
//   data_received_o        one-cycle write strobe to reg_top
//   data_o                 write data to reg_top
//   reg_data_i             read data from reg_top (combinational on address_o)
//   tx_data_o, tx_valid_o  byte to the transmitter, valid
//   tx_ready_i             transmitter accepts byte
//   busy_o                 high in any state other than IDLE
//   err_o                  one-cycle pulse on a timeout or a dropped byte
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module cmd_int #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [6:0] address_o,
  output logic       wr_o,
  output logic       data_received_o,
  output logic [7:0] data_o,
  input  logic [7:0] reg_data_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  // A TIMEOUT_CYCLES value of 0 would give a zero-width counter, so the
  // counter is always at least one bit wide.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_WRITE,
    S_READ,
    S_SEND
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  logic [6:0] address_d;
  logic [7:0] data_d, tx_data_d;
  logic       wr_d, data_received_d, tx_valid_d, busy_d, err_d;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // State register. All registered outputs are updated here as well.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge inputs, whatever the order of the statements.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      address_o       <= '0;
      data_o          <= '0;
      tx_data_o       <= '0;
      wr_o            <= 1'b0;
      data_received_o <= 1'b0;
      tx_valid_o      <= 1'b0;
      busy_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      address_o       <= address_d;
      data_o          <= data_d;
      tx_data_o       <= tx_data_d;
      wr_o            <= wr_d;
      data_received_o <= data_received_d;
      tx_valid_o      <= tx_valid_d;
      busy_o          <= busy_d;
      err_o           <= err_d;
    end
  end

  // Next-state logic.
  // NOTE: each variable written in a combinational block is assigned a default
  // first. Without that default, a path that leaves it unassigned infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (rx_valid_i) state_d = rx_data_i[7] ? S_GET_DATA : S_READ;
      S_GET_DATA: begin
        // When a byte arrives in the same cycle as the timeout, the byte wins.
        if (rx_valid_i)       state_d = S_WRITE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WRITE:    state_d = S_IDLE;
      S_READ:     state_d = S_SEND;
      S_SEND:     if (tx_valid_o && tx_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic. This computes the values that the outputs take after the next edge.
  always_comb begin
    address_d       = address_o;
    data_d          = data_o;
    tx_data_d       = tx_data_o;
    wr_d            = wr_o;
    tx_valid_d      = tx_valid_o;
    data_received_d = 1'b0;
    err_d           = 1'b0;
    cnt_d           = cnt_q;
    busy_d          = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          address_d = rx_data_i[6:0];
          wr_d      = rx_data_i[7];
          cnt_d     = '0;
        end
      end
      S_GET_DATA: begin
        if (rx_valid_i) begin
          data_d          = rx_data_i;
          data_received_d = 1'b1;
        end else if (timeout_hit) begin
          err_d = 1'b1;
          wr_d  = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        wr_d  = 1'b0;
        err_d = rx_valid_i;
      end
      S_READ: begin
        tx_data_d  = reg_data_i;
        tx_valid_d = 1'b1;
        err_d      = rx_valid_i;
      end
      S_SEND: begin
        if (tx_valid_o && tx_ready_i) tx_valid_d = 1'b0;
        err_d = rx_valid_i;
      end
      default: begin
        wr_d       = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cmd_int.sv
// -----------------------------------------------------------------------------
// tb_cmd_int -- self-checking bench for cmd_int (TIMEOUT_CYCLES = 8).
// A small behavioural register file stands in for reg_top. Read results are
// checked through a scoreboard queue. Expected bytes are pushed when a read
// command is driven and popped when the transmit handshake happens.
// Inputs change 1 time unit after a rising edge. The monitors sample on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_cmd_int;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [6:0] address_o;
  logic       wr_o;
  logic       data_received_o;
  logic [7:0] data_o;
  logic [7:0] reg_data_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;
  int strobes = 0;   // data_received_o pulses seen
  int err_pulses = 0;
  int handshakes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem [128] = '{default: 8'h00};

  cmd_int #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .address_o       (address_o),
    .wr_o            (wr_o),
    .data_received_o (data_received_o),
    .data_o          (data_o),
    .reg_data_i      (reg_data_i),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  // reg_top stand-in. The write strobe takes effect at the edge that ends its cycle.
  assign reg_data_i = mem[address_o];
  always @(posedge clk_i) if (data_received_o) mem[address_o] <= data_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: event counters and the scoreboard pop on handshake.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (data_received_o) strobes++;
      if (err_o) err_pulses++;
      if (tx_valid_o && tx_ready_i) begin
        handshakes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_tx: got 0x%0h with empty scoreboard", tx_data_o);
        end else begin
          check("sb_tx_data", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a byte for exactly one rising edge. On return, the block is in
  // the cycle that follows acceptance of the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  typedef struct {
    bit         is_write;
    logic [6:0] addr;
    logic [7:0] data;    // write data, or the expected read byte
  } vec_t;

  vec_t vecs[8];

  task automatic do_read(input logic [6:0] addr, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    send_byte({1'b0, addr});
    check({tag, "_read_busy"}, {31'h0, busy_o}, 32'h1);
    check({tag, "_read_no_valid"}, {31'h0, tx_valid_o}, 32'h0);
    tick();
    check({tag, "_tx_valid"}, {31'h0, tx_valid_o}, 32'h1);
    check({tag, "_tx_data"}, {24'h0, tx_data_o}, {24'h0, exp});
    tick();
    check({tag, "_idle_valid"}, {31'h0, tx_valid_o}, 32'h0);
    check({tag, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [7:0] data, input string tag);
    int s0;
    s0 = strobes;
    send_byte({1'b1, addr});
    check({tag, "_getdata_wr"}, {31'h0, wr_o}, 32'h1);
    check({tag, "_getdata_addr"}, {25'h0, address_o}, {25'h0, addr});
    send_byte(data);
    check({tag, "_strobe"}, {31'h0, data_received_o}, 32'h1);
    check({tag, "_strobe_wr"}, {31'h0, wr_o}, 32'h1);
    check({tag, "_strobe_addr"}, {25'h0, address_o}, {25'h0, addr});
    check({tag, "_strobe_data"}, {24'h0, data_o}, {24'h0, data});
    tick();
    check({tag, "_after_wr"}, {31'h0, wr_o}, 32'h0);
    check({tag, "_after_busy"}, {31'h0, busy_o}, 32'h0);
    check({tag, "_strobe_count"}, strobes - s0, 32'd1);
  endtask

  initial begin
    int s0, e0, h0;

    // The expected read bytes come from the write order in this table.
    vecs[0] = '{1'b1, 7'h05, 8'h3C};
    vecs[1] = '{1'b0, 7'h05, 8'h3C};
    vecs[2] = '{1'b1, 7'h7F, 8'hA5};
    vecs[3] = '{1'b0, 7'h7F, 8'hA5};
    vecs[4] = '{1'b0, 7'h00, 8'h00};
    vecs[5] = '{1'b1, 7'h10, 8'h5A};
    vecs[6] = '{1'b0, 7'h10, 8'h5A};
    vecs[7] = '{1'b0, 7'h05, 8'h3C};

    rst_n_i    = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    tick();
    tick();
    check("reset_outputs",
          {address_o, data_o, tx_data_o, wr_o, data_received_o, tx_valid_o, busy_o, err_o},
          32'h0);
    rst_n_i = 1'b1;
    tick();

    // Table-driven writes and read-backs, issued back to back.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_write) do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      else                  do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // Backpressure: 10 stalled SEND cycles, then exactly one handshake.
    tx_ready_i = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h05);
    tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_valid_%0d", k), {31'h0, tx_valid_o}, 32'h1);
      check($sformatf("bp_data_%0d", k), {24'h0, tx_data_o}, 32'h3C);
      tick();
    end
    h0 = handshakes;
    tx_ready_i = 1'b1;
    tick();
    check("bp_released_valid", {31'h0, tx_valid_o}, 32'h0);
    check("bp_released_busy", {31'h0, busy_o}, 32'h0);
    tick();
    check("bp_single_handshake", handshakes - h0, 32'd1);

    // Timeout: write command 0x81 with no data byte.
    s0 = strobes;
    e0 = err_pulses;
    send_byte(8'h81);
    for (int k = 0; k < 7; k++) tick();
    check("to_pending_err", {31'h0, err_o}, 32'h0);
    check("to_pending_wr", {31'h0, wr_o}, 32'h1);
    tick();
    check("to_err_pulse", {31'h0, err_o}, 32'h1);
    check("to_wr_fall", {31'h0, wr_o}, 32'h0);
    check("to_busy_fall", {31'h0, busy_o}, 32'h0);
    tick();
    check("to_err_once", err_pulses - e0, 32'd1);
    check("to_no_strobe", strobes - s0, 32'd0);
    do_read(7'h01, 8'h00, "to_followup");
    check("to_followup_addr", {25'h0, address_o}, 32'h01);

    // A data byte that arrives in the last cycle before the timeout still wins.
    e0 = err_pulses;
    send_byte(8'h81);
    for (int k = 0; k < 7; k++) tick();
    send_byte(8'hCC);
    check("race_strobe", {31'h0, data_received_o}, 32'h1);
    check("race_no_err", {31'h0, err_o}, 32'h0);
    tick();
    check("race_err_count", err_pulses - e0, 32'd0);
    do_read(7'h01, 8'hCC, "race_readback");

    // Dropped byte in SEND.
    s0 = strobes;
    tx_ready_i = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h05);
    tick();
    send_byte(8'h12);
    check("drop_err", {31'h0, err_o}, 32'h1);
    check("drop_tx_data", {24'h0, tx_data_o}, 32'h3C);
    check("drop_tx_valid", {31'h0, tx_valid_o}, 32'h1);
    tick();
    check("drop_err_cleared", {31'h0, err_o}, 32'h0);
    tx_ready_i = 1'b1;
    tick();
    check("drop_idle", {31'h0, busy_o}, 32'h0);
    check("drop_no_strobe", strobes - s0, 32'd0);

    // Reset while waiting for write data.
    s0 = strobes;
    send_byte(8'h90);
    check("rst_pre_wr", {31'h0, wr_o}, 32'h1);
    rst_n_i = 1'b0;
    #1;
    check("rst_mid_outputs",
          {address_o, data_o, tx_data_o, wr_o, data_received_o, tx_valid_o, busy_o, err_o},
          32'h0);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("rst_no_strobe", strobes - s0, 32'd0);
    do_read(7'h10, 8'h5A, "rst_readback");

    tick();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
